wb_debug_master: RTL and testbench
==================================

# wb_debug_master

Parametrised Wishbone debug master: it turns single commands from the debug/host side into Wishbone classic-cycle transactions on the SoC interconnect. It supports single and incrementing-burst reads and writes, a per-beat timeout, bounded retry on `m_rty_i`, and an error-status response channel. It sits between the debug transport and a master slot of the Wishbone interconnect, and replaces the earlier portless debug master stub.

## Interface
- `dw`, 32, data width
- `aw`, 16, address width (byte address)
- `sw`, `dw/8`, byte-select width; address step per beat
- `lw`, 4, width of `cmd_len_i`; burst = `cmd_len_i+1` beats (1..2^lw)
- `TIMEOUT`, 255, cycles of unanswered `m_stb_o` before abort; 0 disables the timeout
- `RETRIES`, 3, maximum re-issues of a beat after `m_rty_i`
- `clk_i`  in  1  clock
- `rst_ni`  in  1  asynchronous, active-low reset
- `cmd_valid_i`  in  1  command request
- `cmd_ready_o`  out  1  command accepted when high with `cmd_valid_i`
- `cmd_we_i`  in  1  1 = write, 0 = read
- `cmd_addr_i`  in  aw  start byte address
- `cmd_data_i`  in  dw  write data; repeated on every beat (fill)
- `cmd_sel_i`  in  sw  byte selects, same for all beats
- `cmd_len_i`  in  lw  beats minus one
- `rsp_valid_o`  out  1  response valid
- `rsp_ready_i`  in  1  response consumed
- `rsp_data_o`  out  dw  read data; 0 for writes
- `rsp_status_o`  out  2  00 OK, 01 ERR, 10 TIMEOUT, 11 RETRY_EXHAUSTED
- `rsp_last_o`  out  1  final response of the command
- `m_addr_o`  out  aw  Wishbone address
- `m_data_o`  out  dw  Wishbone write data
- `m_data_i`  in  dw  Wishbone read data
- `m_sel_o`  out  sw  byte selects
- `m_we_o`  out  1  write enable
- `m_cyc_o`  out  1  cycle
- `m_stb_o`  out  1  strobe
- `m_ack_i`, `m_err_i`, `m_rty_i`  in  1 each  slave termination

## Operation
- FSM states: IDLE, STB, RSP, BACKOFF.
- IDLE: `cmd_ready_o`=1. On `cmd_valid_i`: latch all `cmd_*`, clear beat, retry and timeout counters, go to STB.
- STB: `m_cyc_o`=`m_stb_o`=1. Address, data, sel and we are driven from the latched registers. Termination priority is err > ack > rty:
  - `m_err_i`: drop cyc/stb; respond ERR, last=1; go to RSP.
  - `m_ack_i`, read: capture `m_data_i`; drop stb and keep cyc; respond OK, last = final beat; go to RSP.
  - `m_ack_i`, write, not final beat: advance address, stay in STB with stb held (back-to-back beats).
  - `m_ack_i`, write, final beat: respond OK, last=1; go to RSP.
  - `m_rty_i`: if the retry count < RETRIES, increment it and go to BACKOFF; otherwise respond RETRY_EXHAUSTED, last=1, go to RSP.
  - Timeout counter reaches TIMEOUT with no termination: respond TIMEOUT, last=1, go to RSP.
- BACKOFF: cyc and stb low for exactly 1 cycle, then back to STB with the same beat and the timeout counter cleared.
- RSP: `rsp_valid_o`=1; outputs are stable until `rsp_ready_i`. On handshake: if last, drop cyc and go to IDLE; otherwise advance address, clear the retry and timeout counters, and go to STB.
- Address arithmetic: next = addr + sw, modulo 2^aw. Wrap past the top is silent.
- The retry counter is per beat. The timeout counter is per strobe attempt.
- One response per read beat. One response per write command, or earlier on abort.

## Timing
- Reset values: `cmd_ready_o`=1, `rsp_valid_o`=0, `rsp_data_o`=0, `rsp_status_o`=00, `rsp_last_o`=0, all `m_*` outputs 0, state = IDLE.
- Reset asserted mid-transaction drops cyc/stb immediately (asynchronously). The in-flight command is lost and no response is produced.
- Command accepted at edge T0 → `m_stb_o` high in cycle T0+1.
- Slave ack sampled at edge Tk → `rsp_valid_o` high in cycle Tk+1.
- Response handshake at edge Tr, next read beat → `m_stb_o` high in cycle Tr+1. `m_cyc_o` stays high throughout.
- Write bursts with zero-wait ack: one beat per cycle.
- TIMEOUT=N: abort after N cycles with stb high, i.e. `rsp_valid_o` in cycle N+1 of the attempt.
- Terminations that arrive outside STB are ignored.

## Test plan
- Single read, addr 0x0010, slave acks after 2 wait states with 0xDEADBEEF → one response: data 0xDEADBEEF, status 00, last=1; `m_cyc_o` low the cycle after the handshake.
- Write burst, len=3, addr 0xFFF8, data 0xA5A5A5A5, zero-wait ack → 4 beats on consecutive cycles at 0xFFF8, 0xFFFC, 0x0000, 0x0004; a single response with status 00, last=1.
- Read burst, len=1, `rsp_ready_i` held low for 5 cycles → `rsp_valid_o` and data stable for those 5 cycles; second beat strobes only after the handshake.
- `m_rty_i` on every attempt, RETRIES=3 → 4 strobes separated by 1-cycle cyc-low gaps, then status 11, last=1.
- Silent slave, TIMEOUT=8 → response with status 10 when stb has been high 8 cycles; `m_err_i` and `m_ack_i` asserted together → status 01.
- `rst_ni` asserted during the second beat of a read burst → all `m_*` outputs 0 immediately; `cmd_ready_o`=1; no response is emitted.

Source files
------------

// File: rtl/wb_debug_master.sv
// wb_debug_master: turns single debug-host commands into Wishbone classic single/burst cycles.
// Ports:
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   cmd_valid_i/cmd_ready_o       command handshake; cmd_we_i, cmd_addr_i, cmd_data_i (fill),
//                                 cmd_sel_i, cmd_len_i (beats-1) are latched on acceptance
//   rsp_valid_o/rsp_ready_i       response handshake; rsp_data_o (read data, 0 for writes),
//                                 rsp_status_o (00 OK, 01 ERR, 10 TIMEOUT, 11 RETRY_EXHAUSTED),
//                                 rsp_last_o (final response of the command)
//   m_*                           Wishbone classic master port
module wb_debug_master #(
    parameter int dw      = 32,
    parameter int aw      = 16,
    parameter int sw      = dw / 8,
    parameter int lw      = 4,
    parameter int TIMEOUT = 255,
    parameter int RETRIES = 3
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          cmd_valid_i,
    output logic          cmd_ready_o,
    input  logic          cmd_we_i,
    input  logic [aw-1:0] cmd_addr_i,
    input  logic [dw-1:0] cmd_data_i,
    input  logic [sw-1:0] cmd_sel_i,
    input  logic [lw-1:0] cmd_len_i,
    output logic          rsp_valid_o,
    input  logic          rsp_ready_i,
    output logic [dw-1:0] rsp_data_o,
    output logic [1:0]    rsp_status_o,
    output logic          rsp_last_o,
    output logic [aw-1:0] m_addr_o,
    output logic [dw-1:0] m_data_o,
    input  logic [dw-1:0] m_data_i,
    output logic [sw-1:0] m_sel_o,
    output logic          m_we_o,
    output logic          m_cyc_o,
    output logic          m_stb_o,
    input  logic          m_ack_i,
    input  logic          m_err_i,
    input  logic          m_rty_i
);
    localparam int TW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
    localparam int RW = RETRIES > 0 ? $clog2(RETRIES + 1) : 1;
    localparam logic [1:0] ST_OK  = 2'b00;
    localparam logic [1:0] ST_ERR = 2'b01;
    localparam logic [1:0] ST_TMO = 2'b10;
    localparam logic [1:0] ST_RTY = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_STB, S_RSP, S_BACKOFF} state_t;

    state_t        r_state, w_next;
    logic [aw-1:0] r_addr;
    logic [dw-1:0] r_data;
    logic [sw-1:0] r_sel;
    logic          r_we;
    logic [lw-1:0] r_len, r_beat;
    logic [TW-1:0] r_to;
    logic [RW-1:0] r_rty;
    logic [dw-1:0] r_rsp_data;
    logic [1:0]    r_rsp_status;
    logic          r_rsp_last;
    logic          w_final, w_to_hit, w_can_retry;
    logic [aw-1:0] w_addr_inc;

    assign w_final     = r_beat == r_len;
    assign w_to_hit    = (TIMEOUT != 0) && (int'(r_to) == TIMEOUT - 1);
    assign w_can_retry = int'(r_rty) < RETRIES;
    assign w_addr_inc  = r_addr + aw'(sw);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= S_IDLE;
        else r_state <= w_next;
    end

    // Termination priority inside a strobe: err > ack > rty > timeout.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    w_next = cmd_valid_i ? S_STB : S_IDLE;
            S_STB:     w_next = m_err_i ? S_RSP
                              : m_ack_i ? ((r_we && !w_final) ? S_STB : S_RSP)
                              : m_rty_i ? (w_can_retry ? S_BACKOFF : S_RSP)
                              : w_to_hit ? S_RSP : S_STB;
            S_RSP:     w_next = !rsp_ready_i ? S_RSP : (r_rsp_last ? S_IDLE : S_STB);
            S_BACKOFF: w_next = S_STB;
            default:   w_next = S_IDLE;
        endcase
    end

    // The cycle is held across a response wait so read bursts stay locked,
    // except after a bus error, which releases the bus at once.
    always_comb begin
        cmd_ready_o = r_state == S_IDLE;
        m_stb_o     = r_state == S_STB;
        m_cyc_o     = (r_state == S_STB) || ((r_state == S_RSP) && (r_rsp_status != ST_ERR));
        rsp_valid_o = r_state == S_RSP;
    end

    assign m_addr_o     = r_addr;
    assign m_data_o     = r_data;
    assign m_sel_o      = r_sel;
    assign m_we_o       = r_we;
    assign rsp_data_o   = r_rsp_data;
    assign rsp_status_o = r_rsp_status;
    assign rsp_last_o   = r_rsp_last;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_addr       <= '0;
            r_data       <= '0;
            r_sel        <= '0;
            r_we         <= 1'b0;
            r_len        <= '0;
            r_beat       <= '0;
            r_to         <= '0;
            r_rty        <= '0;
            r_rsp_data   <= '0;
            r_rsp_status <= ST_OK;
            r_rsp_last   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (cmd_valid_i) begin
                    r_addr <= cmd_addr_i;
                    r_data <= cmd_data_i;
                    r_sel  <= cmd_sel_i;
                    r_we   <= cmd_we_i;
                    r_len  <= cmd_len_i;
                    r_beat <= '0;
                    r_to   <= '0;
                    r_rty  <= '0;
                end
                S_STB: begin
                    if (m_err_i) begin
                        r_rsp_data   <= '0;
                        r_rsp_status <= ST_ERR;
                        r_rsp_last   <= 1'b1;
                    end else if (m_ack_i && r_we && !w_final) begin
                        // Write beats complete back-to-back without a response.
                        r_addr <= w_addr_inc;
                        r_beat <= r_beat + 1'b1;
                        r_to   <= '0;
                        r_rty  <= '0;
                    end else if (m_ack_i) begin
                        r_rsp_data   <= r_we ? '0 : m_data_i;
                        r_rsp_status <= ST_OK;
                        r_rsp_last   <= r_we || w_final;
                    end else if (m_rty_i && w_can_retry) begin
                        r_rty <= r_rty + 1'b1;
                        r_to  <= '0;
                    end else if (m_rty_i || w_to_hit) begin
                        r_rsp_data   <= '0;
                        r_rsp_status <= m_rty_i ? ST_RTY : ST_TMO;
                        r_rsp_last   <= 1'b1;
                    end else begin
                        r_to <= r_to + 1'b1;
                    end
                end
                S_RSP: if (rsp_ready_i && !r_rsp_last) begin
                    r_addr <= w_addr_inc;
                    r_beat <= r_beat + 1'b1;
                    r_to   <= '0;
                    r_rty  <= '0;
                end
                default: r_to <= '0;
            endcase
        end
    end
endmodule

// File: tb/tb_wb_debug_master.sv
// tb_wb_debug_master: self-checking bench for wb_debug_master with a behavioural Wishbone slave.
module tb_wb_debug_master;
    logic        clk_i = 1'b0, rst_ni = 1'b1;
    logic        cmd_valid_i = 1'b0, cmd_we_i = 1'b0, cmd_ready_o;
    logic [15:0] cmd_addr_i = '0;
    logic [31:0] cmd_data_i = '0;
    logic [3:0]  cmd_sel_i = '0, cmd_len_i = '0;
    logic        rsp_valid_o, rsp_ready_i = 1'b0, rsp_last_o;
    logic [31:0] rsp_data_o;
    logic [1:0]  rsp_status_o;
    logic [15:0] m_addr_o;
    logic [31:0] m_data_o, m_data_i = '0;
    logic [3:0]  m_sel_o;
    logic        m_we_o, m_cyc_o, m_stb_o;
    logic        m_ack_i = 1'b0, m_err_i = 1'b0, m_rty_i = 1'b0;

    wb_debug_master #(.dw(32), .aw(16), .sw(4), .lw(4), .TIMEOUT(8), .RETRIES(3)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
        .cmd_addr_i(cmd_addr_i), .cmd_data_i(cmd_data_i), .cmd_sel_i(cmd_sel_i), .cmd_len_i(cmd_len_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_data_o(rsp_data_o),
        .rsp_status_o(rsp_status_o), .rsp_last_o(rsp_last_o),
        .m_addr_o(m_addr_o), .m_data_o(m_data_o), .m_data_i(m_data_i), .m_sel_o(m_sel_o),
        .m_we_o(m_we_o), .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o),
        .m_ack_i(m_ack_i), .m_err_i(m_err_i), .m_rty_i(m_rty_i)
    );

    typedef struct {logic [15:0] a; logic we; logic [31:0] d; logic [3:0] s; int c;} acc_t;
    typedef struct {logic [31:0] d; logic [1:0] st; logic l;} rsp_t;
    typedef struct {
        logic we; logic [15:0] a; logic [31:0] d; logic [3:0] s; logic [3:0] len;
        int mode; int ws; int n; logic [1:0] st; logic [31:0] ld;
    } vec_t;

    int total = 0, bad = 0, cyc_n = 0;
    int s_mode = 0, s_ws = 0, s_cnt = 0;
    logic [31:0] smem [16384];
    logic [31:0] mmem [16384];
    acc_t log_q[$], exp_aq[$];
    rsp_t got_rq[$], exp_rq[$];
    vec_t vt[9];

    initial forever #5 clk_i = ~clk_i;
    initial forever begin @(posedge clk_i); cyc_n++; end

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
        merge = o;
        for (int b = 0; b < 4; b++) if (s[b]) merge[8*b +: 8] = n[8*b +: 8];
    endfunction

    // Slave: mode 0 ack, 1 err, 2 rty, 3 silent, 4 err+ack; s_ws wait states per attempt.
    initial forever begin
        @(negedge clk_i);
        m_ack_i = 1'b0; m_err_i = 1'b0; m_rty_i = 1'b0;
        if (m_cyc_o && m_stb_o && s_mode != 3) begin
            if (s_cnt >= s_ws) begin
                s_cnt = 0;
                log_q.push_back('{m_addr_o, m_we_o, m_data_o, m_sel_o, cyc_n});
                case (s_mode)
                    0: begin
                        m_ack_i = 1'b1;
                        if (m_we_o) smem[m_addr_o[15:2]] = merge(smem[m_addr_o[15:2]], m_data_o, m_sel_o);
                        else m_data_i = smem[m_addr_o[15:2]];
                    end
                    1: m_err_i = 1'b1;
                    2: m_rty_i = 1'b1;
                    default: begin m_err_i = 1'b1; m_ack_i = 1'b1; end
                endcase
            end else s_cnt++;
        end else s_cnt = 0;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: expected responses and bus accesses from the command-level rules.
    task automatic model(input logic we, input logic [15:0] a, input logic [31:0] d,
                         input logic [3:0] s, input logic [3:0] len, input int mode);
        logic [15:0] ba;
        exp_rq.delete(); exp_aq.delete();
        if (mode == 0) begin
            for (int i = 0; i <= int'(len); i++) begin
                ba = a + 16'(4 * i);
                exp_aq.push_back('{ba, we, d, s, 0});
                if (we) mmem[ba[15:2]] = merge(mmem[ba[15:2]], d, s);
                else exp_rq.push_back('{mmem[ba[15:2]], 2'b00, i == int'(len)});
            end
            if (we) exp_rq.push_back('{32'h0, 2'b00, 1'b1});
        end else if (mode == 2) begin
            for (int i = 0; i < 4; i++) exp_aq.push_back('{a, we, d, s, 0});
            exp_rq.push_back('{32'h0, 2'b11, 1'b1});
        end else if (mode == 3) begin
            exp_rq.push_back('{32'h0, 2'b10, 1'b1});
        end else begin
            exp_aq.push_back('{a, we, d, s, 0});
            exp_rq.push_back('{32'h0, 2'b01, 1'b1});
        end
    endtask

    task automatic issue(input logic we, input logic [15:0] a, input logic [31:0] d,
                         input logic [3:0] s, input logic [3:0] len);
        @(negedge clk_i);
        check("cmd_ready_idle", cmd_ready_o, 1);
        log_q.delete();
        cmd_valid_i = 1'b1; cmd_we_i = we; cmd_addr_i = a; cmd_data_i = d; cmd_sel_i = s; cmd_len_i = len;
        @(negedge clk_i);
        cmd_valid_i = 1'b0;
    endtask

    task automatic wait_rsp();
        int n = 0;
        while (!rsp_valid_o && n < 100) begin @(negedge clk_i); n++; end
        check("rsp_wait", rsp_valid_o, 1);
    endtask

    task automatic do_cmd(input logic we, input logic [15:0] a, input logic [31:0] d,
                          input logic [3:0] s, input logic [3:0] len, input int rdy_pct);
        int guard = 0;
        bit done = 0;
        got_rq.delete();
        issue(we, a, d, s, len);
        while (!done && guard < 2000) begin
            if (rsp_valid_o && int'($urandom_range(99)) < rdy_pct) begin
                rsp_ready_i = 1'b1;
                got_rq.push_back('{rsp_data_o, rsp_status_o, rsp_last_o});
                done = rsp_last_o;
            end else rsp_ready_i = 1'b0;
            @(negedge clk_i);
            guard++;
        end
        rsp_ready_i = 1'b0;
        check("cmd_complete", done, 1);
    endtask

    task automatic compare_model(input string tag);
        check({tag, "_nrsp"}, got_rq.size(), exp_rq.size());
        for (int i = 0; i < got_rq.size() && i < exp_rq.size(); i++) begin
            check({tag, "_rdata"}, got_rq[i].d, exp_rq[i].d);
            check({tag, "_status"}, got_rq[i].st, exp_rq[i].st);
            check({tag, "_last"}, got_rq[i].l, exp_rq[i].l);
        end
        check({tag, "_nacc"}, log_q.size(), exp_aq.size());
        for (int i = 0; i < log_q.size() && i < exp_aq.size(); i++) begin
            check({tag, "_addr"}, log_q[i].a, exp_aq[i].a);
            check({tag, "_we"}, log_q[i].we, exp_aq[i].we);
            check({tag, "_sel"}, log_q[i].s, exp_aq[i].s);
            if (exp_aq[i].we) check({tag, "_wdata"}, log_q[i].d, exp_aq[i].d);
        end
    endtask

    initial begin
        int n;
        for (int i = 0; i < 16384; i++) begin
            smem[i] = (i * 32'h9E3779B1) ^ 32'h5A5A0F0F;
            mmem[i] = smem[i];
        end
        smem[4] = 32'hDEADBEEF;    mmem[4] = 32'hDEADBEEF;
        smem[16'h40] = 32'hCAFEF00D; mmem[16'h40] = 32'hCAFEF00D;

        vt[0] = '{1'b0, 16'h0010, 32'h0,        4'hF,    4'd0, 0, 2, 1, 2'b00, 32'hDEADBEEF};
        vt[1] = '{1'b1, 16'hFFF8, 32'hA5A5A5A5, 4'hF,    4'd3, 0, 0, 1, 2'b00, 32'h0};
        vt[2] = '{1'b0, 16'hFFFC, 32'h0,        4'hF,    4'd1, 0, 1, 2, 2'b00, 32'hA5A5A5A5};
        vt[3] = '{1'b1, 16'h0100, 32'h12345678, 4'b0011, 4'd0, 0, 0, 1, 2'b00, 32'h0};
        vt[4] = '{1'b0, 16'h0100, 32'h0,        4'hF,    4'd0, 0, 0, 1, 2'b00, 32'hCAFE5678};
        vt[5] = '{1'b1, 16'h0100, 32'h0,        4'hF,    4'd0, 4, 0, 1, 2'b01, 32'h0};
        vt[6] = '{1'b0, 16'h0100, 32'h0,        4'hF,    4'd2, 2, 0, 1, 2'b11, 32'h0};
        vt[7] = '{1'b0, 16'h0104, 32'h0,        4'hF,    4'd0, 3, 0, 1, 2'b10, 32'h0};
        vt[8] = '{1'b0, 16'h0100, 32'h0,        4'hF,    4'd0, 0, 3, 1, 2'b00, 32'hCAFE5678};

        // Reset values
        #2 rst_ni = 1'b0;
        @(negedge clk_i);
        check("rst_cmd_ready", cmd_ready_o, 1);
        check("rst_rsp_valid", rsp_valid_o, 0);
        check("rst_rsp_fields", {rsp_data_o, rsp_status_o, rsp_last_o}, 0);
        check("rst_m_ctrl", {m_cyc_o, m_stb_o, m_we_o}, 0);
        check("rst_m_bus", {m_addr_o, m_sel_o}, 0);
        check("rst_m_data", m_data_o, 0);
        @(negedge clk_i);
        rst_ni = 1'b1;

        // Single read with 2 wait states
        s_mode = 0; s_ws = 2;
        issue(1'b0, 16'h0010, 32'h0, 4'hF, 4'd0);
        check("rd_stb_t1", {m_cyc_o, m_stb_o, m_we_o}, 3'b110);
        check("rd_addr", m_addr_o, 16'h0010);
        @(negedge clk_i);
        @(negedge clk_i);
        check("rd_stb_wait", {m_stb_o, rsp_valid_o}, 2'b10);
        @(negedge clk_i);
        check("rd_rsp_valid", {rsp_valid_o, m_stb_o, m_cyc_o}, 3'b101);
        check("rd_rsp", {rsp_data_o, rsp_status_o, rsp_last_o}, {32'hDEADBEEF, 2'b00, 1'b1});
        rsp_ready_i = 1'b1;
        @(negedge clk_i);
        rsp_ready_i = 1'b0;
        check("rd_after_hs", {m_cyc_o, rsp_valid_o, cmd_ready_o}, 3'b001);

        // Write burst across the address wrap, zero-wait
        s_ws = 0;
        model(1'b1, 16'hFFF8, 32'hA5A5A5A5, 4'hF, 4'd3, 0);
        do_cmd(1'b1, 16'hFFF8, 32'hA5A5A5A5, 4'hF, 4'd3, 100);
        compare_model("wburst");
        for (int i = 1; i < log_q.size(); i++) check("wburst_gap", log_q[i].c - log_q[i-1].c, 1);

        // Read burst with the response held for 5 cycles
        s_ws = 1;
        model(1'b0, 16'h0000, 32'h0, 4'hF, 4'd1, 0);
        issue(1'b0, 16'h0000, 32'h0, 4'hF, 4'd1);
        wait_rsp();
        check("hold_d0", rsp_data_o, exp_rq[0].d);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk_i);
            check("hold_valid", {rsp_valid_o, m_stb_o, m_cyc_o}, 3'b101);
            check("hold_data", {rsp_data_o, rsp_last_o}, {exp_rq[0].d, 1'b0});
        end
        rsp_ready_i = 1'b1;
        @(negedge clk_i);
        rsp_ready_i = 1'b0;
        check("beat2_stb", {m_stb_o, m_cyc_o, rsp_valid_o}, 3'b110);
        check("beat2_addr", m_addr_o, 16'h0004);
        wait_rsp();
        check("beat2_rsp", {rsp_data_o, rsp_status_o, rsp_last_o}, {exp_rq[1].d, 2'b00, 1'b1});
        rsp_ready_i = 1'b1;
        @(negedge clk_i);
        rsp_ready_i = 1'b0;

        // Retry on every attempt
        s_mode = 2; s_ws = 0;
        model(1'b0, 16'h0020, 32'h0, 4'hF, 4'd0, 2);
        do_cmd(1'b0, 16'h0020, 32'h0, 4'hF, 4'd0, 100);
        compare_model("retry");
        for (int i = 1; i < log_q.size(); i++) check("retry_gap", log_q[i].c - log_q[i-1].c, 2);

        // Silent slave: timeout after 8 strobe cycles
        s_mode = 3;
        issue(1'b0, 16'h0300, 32'h0, 4'hF, 4'd0);
        n = 0;
        while (m_stb_o && n < 50) begin n++; @(negedge clk_i); end
        check("tmo_cycles", n, 8);
        check("tmo_rsp", {rsp_valid_o, rsp_status_o, rsp_last_o}, 4'b1101);
        rsp_ready_i = 1'b1;
        @(negedge clk_i);
        rsp_ready_i = 1'b0;

        // Reset during the second beat of a read burst
        s_mode = 0; s_ws = 3;
        issue(1'b0, 16'h0200, 32'h0, 4'hF, 4'd3);
        wait_rsp();
        rsp_ready_i = 1'b1;
        @(negedge clk_i);
        rsp_ready_i = 1'b0;
        check("rst_beat2_stb", m_stb_o, 1);
        #2 rst_ni = 1'b0;
        #1;
        check("arst_m_ctrl", {m_cyc_o, m_stb_o, m_we_o}, 0);
        check("arst_m_addr", m_addr_o, 0);
        check("arst_ready", {cmd_ready_o, rsp_valid_o}, 2'b10);
        @(negedge clk_i);
        rst_ni = 1'b1;
        n = 0;
        for (int k = 0; k < 12; k++) begin @(negedge clk_i); if (rsp_valid_o) n++; end
        check("arst_no_rsp", n, 0);

        // Table of directed commands
        for (int i = 0; i < 9; i++) begin
            s_mode = vt[i].mode; s_ws = vt[i].ws;
            model(vt[i].we, vt[i].a, vt[i].d, vt[i].s, vt[i].len, vt[i].mode);
            do_cmd(vt[i].we, vt[i].a, vt[i].d, vt[i].s, vt[i].len, 100);
            check("vec_nrsp", got_rq.size(), vt[i].n);
            if (got_rq.size() > 0) begin
                check("vec_status", got_rq[got_rq.size()-1].st, vt[i].st);
                check("vec_data", got_rq[got_rq.size()-1].d, vt[i].ld);
            end
            compare_model("vec");
        end

        // Randomized commands against the reference
        for (int i = 0; i < 60; i++) begin
            logic we;
            logic [15:0] a;
            logic [31:0] d;
            logic [3:0] s, len;
            int r;
            we = 1'($urandom_range(1));
            a = 16'($urandom);
            d = $urandom;
            s = 4'($urandom_range(15));
            len = 4'($urandom_range(7));
            r = int'($urandom_range(9));
            s_mode = r < 7 ? 0 : r - 6;
            s_ws = int'($urandom_range(3));
            model(we, a, d, s, len, s_mode);
            do_cmd(we, a, d, s, len, int'($urandom_range(30, 100)));
            compare_model("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
